mul_div_unit: RTL and testbench
===============================

Name: mul_div_unit

Overview:
Sequential RV32M multiply/divide unit that sits beside the combinational ALU in the execute stage of the multi-cycle core. It uses a radix-2 shift-add / restoring-divide iteration over DATA_WIDTH cycles. The control FSM launches an operation with start_i and waits for done_o. It supports all eight M-extension ops, RISC-V divide-by-zero and overflow results, abort, and VNCZ-style flags.

Parameters:
DATA_WIDTH, 32, operand/result width (>= 4)
CNT_WIDTH, $clog2(DATA_WIDTH), width of the iteration counter

Ports:
clk_i  input  1  clock, rising edge
reset_ni  input  1  asynchronous active-low reset
start_i  input  1  launch op; sampled only in IDLE or DONE
kill_i  input  1  abort in-flight op
func_op_i  input  3  MulDiv_Ops: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
a_i  input  DATA_WIDTH  rs1 (multiplicand/dividend)
b_i  input  DATA_WIDTH  rs2 (multiplier/divisor)
busy_o  output  1  op in progress
done_o  output  1  one-cycle pulse: y_o/flags_o valid
y_o  output  DATA_WIDTH  result, held until next accepted start
flags_o  output  `FlagSize  {V=div overflow, N=y_o MSB, C=divide-by-zero, Z=y_o==0}

Behaviour:
- Reset (async assert, sync release): state=IDLE, busy_o=0, done_o=0, y_o=0, flags_o=0, counter=0, internal registers cleared.
- States: IDLE, CALC, FIX, DONE.
- IDLE/DONE with start_i=1 and kill_i=0: latch op and operands. Compute magnitudes (signed ops per operand: MULH both, MULHSU a only, DIV/REM both). Record result sign. Set counter=DATA_WIDTH-1. Go to CALC, or go to DONE directly for special cases.
- Special cases are checked in the start cycle:
  - DIV/DIVU with b=0: y=all ones, C=1.
  - REM/REMU with b=0: y=a, C=1.
  - DIV with a=most-negative and b=-1: y=a, V=1.
  - REM with the same operands: y=0, V=1.
  - In all special cases done_o is high 1 edge after start.
- CALC, one iteration per cycle:
  - Multiply: 2*DATA_WIDTH product register; conditional add, then shift right.
  - Divide: restoring shift-subtract on {rem,quot}.
  - Counter decrements; at 0 go to FIX.
- FIX (1 cycle):
  - Negate the product/quotient if the result sign is negative.
  - Remainder takes the dividend's sign.
  - Select low half (MUL), high half (MULH*), quotient or remainder.
  - Register y_o and flags; go to DONE.
- DONE: done_o=1 for exactly this cycle. Without a new start, go to IDLE next edge. A start in DONE is accepted back-to-back.
- Latency: start sampled at edge k → done_o high after edge k+DATA_WIDTH+2 (34 for W=32). Special cases: after edge k+1.
- busy_o=1 in CALC and FIX only.
- start_i in CALC/FIX is ignored and does not queue.
- func_op_i, a_i and b_i are don't-care after the start cycle.
- kill_i in CALC/FIX: go to IDLE next edge. No done_o. y_o and flags_o keep their previous values.
- kill_i in IDLE/DONE: no effect except that it blocks a same-cycle start (kill wins).
- Reset mid-operation: immediate async return to the reset values.
- Arithmetic is modulo 2^DATA_WIDTH. All negations are two's complement, with no extra overflow beyond V as defined.
- Undefined func_op_i cannot occur (3-bit enum fully decoded).

Decomposition:
- Shared package holds:
  - typedef enum logic [2:0] MulDiv_Ops, with encodings matching funct3 (MUL=0 … REMU=7).
  - The FSM state enum MulDivState.
  - The flag-index constants (V=3, N=2, C=1, Z=0) shared with the ALU.
- One sub-module: md_iter_core, the per-cycle add/subtract-and-shift datapath (combinational, one iteration). The parent owns the FSM, counter, sign fix-up and special cases.

Test Plan:
- MUL a=7, b=0xFFFFFFFD (-3) → y=0xFFFFFFEB, N=1, done after 34 edges, busy high 33 cycles. MULHU a=b=0xFFFFFFFF → y=0xFFFFFFFE.
- MULH a=b=0x80000000 → y=0x40000000. MULHSU a=0xFFFFFFFF (signed -1), b=0xFFFFFFFF → y=0xFFFFFFFF.
- DIV a=0xFFFFFFF9 (-7), b=2 → y=0xFFFFFFFD. REM same operands → y=0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2, Z=0.
- DIVU a=5, b=0 → y=0xFFFFFFFF, C=1, done after 1 edge. REM a=5, b=0 → y=5, C=1. DIV 0x80000000 / 0xFFFFFFFF → y=0x80000000, V=1. REM same → y=0, Z=1, V=1.
- Kill at CALC cycle 10 → busy_o low next edge, no done_o, y_o unchanged. Start on the same cycle as kill in IDLE → ignored.
- Back-to-back start in DONE → second op accepted with no idle gap. start_i while busy → ignored. reset_ni pulled low mid-CALC → all outputs 0 immediately. A new op after release completes normally.

Source files
------------

// File: rtl/mul_div_unit_pkg.sv
// Shared types for the RV32M multiply/divide unit.
// Op encodings follow funct3; flag indices are shared with the ALU.
package mul_div_unit_pkg;

  typedef enum logic [2:0] {
    MUL    = 3'd0,
    MULH   = 3'd1,
    MULHSU = 3'd2,
    MULHU  = 3'd3,
    DIV    = 3'd4,
    DIVU   = 3'd5,
    REM    = 3'd6,
    REMU   = 3'd7
  } MulDiv_Ops;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } MulDivState;

  localparam int FlagSize = 4;
  localparam int FLAG_V   = 3;
  localparam int FLAG_N   = 2;
  localparam int FLAG_C   = 1;
  localparam int FLAG_Z   = 0;

endpackage

// File: rtl/mul_div_unit_iter.sv
// One radix-2 iteration: shift-add multiply or restoring divide step.
// hi/lo hold {product} for multiply and {rem,quot} for divide.
module md_iter_core #(
  parameter int W = 32
) (
  input  logic         div_i,
  input  logic [W-1:0] hi_i,
  input  logic [W-1:0] lo_i,
  input  logic [W-1:0] m_i,
  output logic [W-1:0] hi_o,
  output logic [W-1:0] lo_o
);

  logic [W:0] sum;
  logic [W:0] sh;
  logic [W:0] diff;

  assign sum  = lo_i[0] ? ({1'b0, hi_i} + {1'b0, m_i})
                        : {1'b0, hi_i};
  assign sh   = {hi_i, lo_i[W-1]};
  assign diff = sh - {1'b0, m_i};

  always_comb begin
    hi_o = sum[W:1];
    lo_o = {sum[0], lo_i[W-1:1]};
    if (div_i) begin
      // remainder < divisor, so the shifted value fits in W+1 bits
      hi_o = diff[W] ? sh[W-1:0] : diff[W-1:0];
      lo_o = {lo_i[W-2:0], ~diff[W]};
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Sequential RV32M multiply/divide unit, one radix-2 step per cycle.
// FSM, sign handling and RISC-V divide special cases live here.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = $clog2(DATA_WIDTH)
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic                  start_i,
  input  logic                  kill_i,
  input  MulDiv_Ops             func_op_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] y_o,
  output logic [FlagSize-1:0]   flags_o
);

  localparam int W = DATA_WIDTH;

  MulDivState           state_q, state_d;
  MulDiv_Ops            op_q, op_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [W-1:0]         hi_q, hi_d;
  logic [W-1:0]         lo_q, lo_d;
  logic [W-1:0]         m_q, m_d;
  logic [W-1:0]         y_q, y_d;
  logic                 neg_q, neg_d;
  logic                 aneg_q, aneg_d;
  logic [FlagSize-1:0]  flags_q, flags_d;

  logic [W-1:0]   hi_n, lo_n;
  logic           a_sgn, b_sgn;
  logic [W-1:0]   a_mag, b_mag;
  logic           div_zero, div_ovf;
  logic [W-1:0]   sp_y;
  logic [2*W-1:0] prod, prod_s;
  logic [W-1:0]   quot, rem, res;

  function automatic logic [FlagSize-1:0] mk_flags(
    input logic         v,
    input logic         c,
    input logic [W-1:0] y
  );
    logic [FlagSize-1:0] f;
    f         = '0;
    f[FLAG_V] = v;
    f[FLAG_N] = y[W-1];
    f[FLAG_C] = c;
    f[FLAG_Z] = (y == '0);
    return f;
  endfunction

  md_iter_core #(
    .W(W)
  ) u_iter (
    .div_i(op_q[2]),
    .hi_i (hi_q),
    .lo_i (lo_q),
    .m_i  (m_q),
    .hi_o (hi_n),
    .lo_o (lo_n)
  );

  assign a_sgn = (func_op_i inside {MULH, MULHSU, DIV, REM})
               & a_i[W-1];
  assign b_sgn = (func_op_i inside {MULH, DIV, REM})
               & b_i[W-1];
  assign a_mag = a_sgn ? -a_i : a_i;
  assign b_mag = b_sgn ? -b_i : b_i;

  assign div_zero = func_op_i[2] && (b_i == '0);
  assign div_ovf  = (func_op_i inside {DIV, REM})
                 && (a_i == {1'b1, {(W-1){1'b0}}})
                 && (b_i == '1);
  assign sp_y = div_zero ? (func_op_i[1] ? a_i : '1)
                         : (func_op_i[1] ? '0 : a_i);

  assign prod   = {hi_q, lo_q};
  assign prod_s = neg_q ? -prod : prod;
  assign quot   = neg_q ? -lo_q : lo_q;
  assign rem    = aneg_q ? -hi_q : hi_q;

  always_comb begin
    res = quot;
    unique case (op_q)
      MUL:                 res = prod_s[W-1:0];
      MULH, MULHSU, MULHU: res = prod_s[2*W-1:W];
      DIV, DIVU:           res = quot;
      REM, REMU:           res = rem;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    m_d     = m_q;
    y_d     = y_q;
    neg_d   = neg_q;
    aneg_d  = aneg_q;
    flags_d = flags_q;
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start_i && !kill_i) begin
          op_d    = func_op_i;
          cnt_d   = CNT_WIDTH'(W - 1);
          hi_d    = '0;
          lo_d    = func_op_i[2] ? a_mag : b_mag;
          m_d     = func_op_i[2] ? b_mag : a_mag;
          neg_d   = a_sgn ^ b_sgn;
          aneg_d  = a_sgn;
          state_d = CALC;
          if (div_zero || div_ovf) begin
            y_d     = sp_y;
            flags_d = mk_flags(div_ovf, div_zero, sp_y);
            state_d = DONE;
          end
        end
      end
      CALC: begin
        if (kill_i) begin
          state_d = IDLE;
        end else begin
          hi_d = hi_n;
          lo_d = lo_n;
          if (cnt_q == '0) state_d = FIX;
          else cnt_d = cnt_q - CNT_WIDTH'(1);
        end
      end
      FIX: begin
        if (kill_i) begin
          state_d = IDLE;
        end else begin
          y_d     = res;
          flags_d = mk_flags(1'b0, 1'b0, res);
          state_d = DONE;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= IDLE;
      op_q    <= MUL;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      m_q     <= '0;
      y_q     <= '0;
      neg_q   <= 1'b0;
      aneg_q  <= 1'b0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      m_q     <= m_d;
      y_q     <= y_d;
      neg_q   <= neg_d;
      aneg_q  <= aneg_d;
      flags_q <= flags_d;
    end
  end

  assign busy_o  = (state_q == CALC) || (state_q == FIX);
  assign done_o  = (state_q == DONE);
  assign y_o     = y_q;
  assign flags_o = flags_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit.
// Flags are {V,N,C,Z}; edge counts include the start-sampling edge.
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  logic        clk_i = 1'b0;
  logic        reset_ni;
  logic        start_i;
  logic        kill_i;
  MulDiv_Ops   func_op_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] y_o;
  logic [3:0]  flags_o;

  int checks   = 0;
  int failures = 0;

  mul_div_unit #(
    .DATA_WIDTH(32)
  ) dut (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .start_i  (start_i),
    .kill_i   (kill_i),
    .func_op_i(func_op_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .y_o      (y_o),
    .flags_o  (flags_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic launch(input MulDiv_Ops op,
                        input logic [31:0] a,
                        input logic [31:0] b);
    func_op_i = op;
    a_i       = a;
    b_i       = b;
    start_i   = 1'b1;
  endtask

  task automatic wait_done(output int edges, output int busy);
    edges = 0;
    busy  = 0;
    do begin
      step();
      start_i   = 1'b0;
      a_i       = $urandom;
      b_i       = $urandom;
      func_op_i = MulDiv_Ops'($urandom_range(0, 7));
      edges++;
      if (busy_o) busy++;
    end while (!done_o && edges < 100);
  endtask

  task automatic run_op(input string tag,
                        input MulDiv_Ops op,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [31:0] ey,
                        input logic [3:0] ef,
                        input int eedges);
    int e, bz;
    launch(op, a, b);
    wait_done(e, bz);
    check({tag, "_edges"}, e, eedges);
    check({tag, "_busy"}, bz, (eedges > 1) ? eedges - 1 : 0);
    check({tag, "_y"}, y_o, ey);
    check({tag, "_flags"}, {28'd0, flags_o}, {28'd0, ef});
    step();
    check({tag, "_pulse"}, {31'd0, done_o}, 32'd0);
  endtask

  initial begin
    int e, bz, seen;
    reset_ni  = 1'b0;
    start_i   = 1'b0;
    kill_i    = 1'b0;
    func_op_i = MUL;
    a_i       = '0;
    b_i       = '0;
    #12;
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_done", {31'd0, done_o}, 32'd0);
    check("rst_y", y_o, 32'd0);
    check("rst_flags", {28'd0, flags_o}, 32'd0);
    @(negedge clk_i);
    reset_ni = 1'b1;
    step();

    run_op("mul", MUL, 32'd7, 32'hFFFFFFFD,
           32'hFFFFFFEB, 4'b0100, 34);
    run_op("mulhu", MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF,
           32'hFFFFFFFE, 4'b0100, 34);
    run_op("mulh", MULH, 32'h80000000, 32'h80000000,
           32'h40000000, 4'b0000, 34);
    run_op("mulhsu", MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF,
           32'hFFFFFFFF, 4'b0100, 34);
    run_op("div", DIV, 32'hFFFFFFF9, 32'd2,
           32'hFFFFFFFD, 4'b0100, 34);
    run_op("rem", REM, 32'hFFFFFFF9, 32'd2,
           32'hFFFFFFFF, 4'b0100, 34);
    run_op("divu", DIVU, 32'd100, 32'd7,
           32'd14, 4'b0000, 34);
    run_op("divu_z", DIVU, 32'd5, 32'd0,
           32'hFFFFFFFF, 4'b0110, 1);
    run_op("rem_z", REM, 32'd5, 32'd0,
           32'd5, 4'b0010, 1);
    run_op("div_ovf", DIV, 32'h80000000, 32'hFFFFFFFF,
           32'h80000000, 4'b1100, 1);
    run_op("rem_ovf", REM, 32'h80000000, 32'hFFFFFFFF,
           32'd0, 4'b1001, 1);
    run_op("remu", REMU, 32'd100, 32'd7,
           32'd2, 4'b0000, 34);

    // kill at CALC cycle 10: outputs keep the REMU result
    launch(MUL, 32'd3, 32'd5);
    step();
    start_i = 1'b0;
    repeat (9) step();
    kill_i = 1'b1;
    step();
    kill_i = 1'b0;
    check("kill_busy", {31'd0, busy_o}, 32'd0);
    check("kill_done", {31'd0, done_o}, 32'd0);
    check("kill_y", y_o, 32'd2);
    check("kill_flags", {28'd0, flags_o}, 32'd0);
    seen = 0;
    repeat (40) begin
      step();
      if (done_o || busy_o) seen++;
    end
    check("kill_quiet", seen, 0);

    // start together with kill in IDLE is dropped
    launch(MUL, 32'd3, 32'd5);
    kill_i = 1'b1;
    step();
    start_i = 1'b0;
    kill_i  = 1'b0;
    check("sk_busy", {31'd0, busy_o}, 32'd0);
    check("sk_done", {31'd0, done_o}, 32'd0);

    // back-to-back start while in DONE
    launch(DIVU, 32'd100, 32'd7);
    wait_done(e, bz);
    check("b2b_first_y", y_o, 32'd14);
    check("b2b_first_done", {31'd0, done_o}, 32'd1);
    launch(MUL, 32'd6, 32'd7);
    step();
    start_i = 1'b0;
    check("b2b_busy", {31'd0, busy_o}, 32'd1);
    wait_done(e, bz);
    check("b2b_edges", e, 33);
    check("b2b_y", y_o, 32'd42);
    step();

    // start while busy is ignored
    launch(MUL, 32'd9, 32'd5);
    step();
    start_i = 1'b0;
    repeat (4) step();
    launch(DIVU, 32'd100, 32'd7);
    wait_done(e, bz);
    check("ign_edges", e + 5, 34);
    check("ign_y", y_o, 32'd45);
    step();

    // async reset in the middle of CALC
    launch(MUL, 32'd7, 32'hFFFFFFFD);
    step();
    start_i = 1'b0;
    repeat (6) step();
    reset_ni = 1'b0;
    #1;
    check("mrst_busy", {31'd0, busy_o}, 32'd0);
    check("mrst_done", {31'd0, done_o}, 32'd0);
    check("mrst_y", y_o, 32'd0);
    check("mrst_flags", {28'd0, flags_o}, 32'd0);
    @(negedge clk_i);
    reset_ni = 1'b1;
    step();
    run_op("post_rst", DIVU, 32'd100, 32'd7,
           32'd14, 4'b0000, 34);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
